// File: rtl/ad9361_tx_framer.sv
// ad9361_tx_framer: frames 48-bit two-channel sample words onto the AD9361 TX_FRAME/P0/P1 bus, one word per slot pair.
// Latency: tx_frame=1 appears in the cycle the FSM sits in CH0 (cycle after the PRIME->CH0 edge); each word spans two cycles.
// Backpressure: s_axis_tready low only while the input FIFO is full (registered flag); an empty FIFO yields a framed zero pair.

module ad9361_tx_framer_fifo #(
  parameter int LOG2_DEPTH = 2,
  parameter int WIDTH      = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_vld_i,
  output logic                  push_rdy_o,
  input  logic [WIDTH-1:0]      push_dat_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      pop_dat_o,
  output logic [LOG2_DEPTH:0]   count_o
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0]   FULL_CNT = DEPTH[LOG2_DEPTH:0];
  localparam logic [LOG2_DEPTH:0]   CNT_ONE  = {{LOG2_DEPTH{1'b0}}, 1'b1};
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = {{(LOG2_DEPTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q;
  logic [LOG2_DEPTH-1:0] rd_ptr_q;
  logic [LOG2_DEPTH:0]   count_q;
  logic [LOG2_DEPTH:0]   count_d;
  logic                  full_q;
  logic                  push;
  logic                  pop;

  // Ready comes from the registered full flag only, so a pop cannot open a slot in the same cycle.
  assign push_rdy_o = ~full_q;
  assign push       = push_vld_i & ~full_q;
  assign pop        = pop_i & (count_q != '0);
  assign pop_dat_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Occupancy next state; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally at the depth; full flag tracks the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

module ad9361_tx_framer #(
  parameter int FIFO_LOG2_DEPTH = 2,
  parameter int START_LEVEL     = 2,
  parameter int REVERSE_DATA    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [47:0] s_axis_tdata,
  output logic        tx_frame,
  output logic [11:0] tx_data_p0,
  output logic [11:0] tx_data_p1,
  output logic        active,
  output logic        underrun,
  output logic [15:0] underrun_count
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_CH0   = 2'd2;
  localparam logic [1:0] S_CH1   = 2'd3;

  localparam logic [FIFO_LOG2_DEPTH:0] START_CNT = START_LEVEL[FIFO_LOG2_DEPTH:0];

  logic [1:0]               state_q, state_d;
  logic [47:0]              hold_q, hold_d;
  logic                     frame_q, frame_d;
  logic [11:0]              p0_q, p0_d;
  logic [11:0]              p1_q, p1_d;
  logic                     underrun_q;
  logic [15:0]              ucount_q;
  logic                     pop_req;
  logic                     underrun_evt;
  logic [47:0]              fifo_dat;
  logic [FIFO_LOG2_DEPTH:0] fifo_count;
  logic [23:0]              slot_hi;
  logic [23:0]              slot_lo;

  ad9361_tx_framer_fifo #(
    .LOG2_DEPTH (FIFO_LOG2_DEPTH),
    .WIDTH      (48)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (s_axis_tvalid),
    .push_rdy_o (s_axis_tready),
    .push_dat_i (s_axis_tdata),
    .pop_i      (pop_req),
    .pop_dat_o  (fifo_dat),
    .count_o    (fifo_count)
  );

  // Frame FSM: a started pair always completes; underruns substitute a zero word.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    pop_req      = 1'b0;
    underrun_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_PRIME;
      end
      S_PRIME: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (fifo_count >= START_CNT) begin
          state_d = S_CH0;
          pop_req = 1'b1;
          hold_d  = fifo_dat;
        end
      end
      S_CH0: begin
        state_d = S_CH1;
      end
      S_CH1: begin
        if (enable) begin
          state_d = S_CH0;
          if (fifo_count != '0) begin
            pop_req = 1'b1;
            hold_d  = fifo_dat;
          end else begin
            underrun_evt = 1'b1;
            hold_d       = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slot mapping: {q,i} of the channel for the frame-high and frame-low slots.
  always_comb begin
    slot_hi = (REVERSE_DATA != 0) ? hold_d[47:24] : hold_d[23:0];
    slot_lo = (REVERSE_DATA != 0) ? hold_d[23:0]  : hold_d[47:24];
    frame_d = 1'b0;
    p0_d    = '0;
    p1_d    = '0;
    case (state_d)
      S_CH0: begin
        frame_d = 1'b1;
        p0_d    = slot_hi[11:0];
        p1_d    = slot_hi[23:12];
      end
      S_CH1: begin
        p0_d = slot_lo[11:0];
        p1_d = slot_lo[23:12];
      end
      default: begin
        frame_d = 1'b0;
      end
    endcase
  end

  // State, holding word, registered bus outputs and sticky underrun statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      frame_q    <= 1'b0;
      p0_q       <= '0;
      p1_q       <= '0;
      underrun_q <= 1'b0;
      ucount_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      if (underrun_evt) begin
        underrun_q <= 1'b1;
        if (ucount_q != 16'hFFFF) ucount_q <= ucount_q + 16'd1;
      end
    end
  end

  assign tx_frame       = frame_q;
  assign tx_data_p0     = p0_q;
  assign tx_data_p1     = p1_q;
  assign active         = (state_q == S_CH0) || (state_q == S_CH1);
  assign underrun       = underrun_q;
  assign underrun_count = ucount_q;
endmodule

// File: tb/tb_ad9361_tx_framer.sv
// Directed bench for ad9361_tx_framer: default instance plus a REVERSE_DATA=1 instance.
// Steps advance one clock; outputs are sampled 1 time unit after the rising edge.
// Expected values are hand-computed constants per step.

module tb_ad9361_tx_framer;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        tvalid;
  logic [47:0] tdata;
  logic        tready;
  logic        frame;
  logic [11:0] p0;
  logic [11:0] p1;
  logic        act;
  logic        urun;
  logic [15:0] ucnt;

  logic        r_enable;
  logic        r_tvalid;
  logic [47:0] r_tdata;
  logic        r_tready;
  logic        r_frame;
  logic [11:0] r_p0;
  logic [11:0] r_p1;
  logic        r_act;
  logic        r_urun;
  logic [15:0] r_ucnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ad9361_tx_framer dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .s_axis_tvalid  (tvalid),
    .s_axis_tready  (tready),
    .s_axis_tdata   (tdata),
    .tx_frame       (frame),
    .tx_data_p0     (p0),
    .tx_data_p1     (p1),
    .active         (act),
    .underrun       (urun),
    .underrun_count (ucnt)
  );

  ad9361_tx_framer #(.START_LEVEL(1), .REVERSE_DATA(1)) dut_rev (
    .clk            (clk),
    .rst            (rst),
    .enable         (r_enable),
    .s_axis_tvalid  (r_tvalid),
    .s_axis_tready  (r_tready),
    .s_axis_tdata   (r_tdata),
    .tx_frame       (r_frame),
    .tx_data_p0     (r_p0),
    .tx_data_p1     (r_p1),
    .active         (r_act),
    .underrun       (r_urun),
    .underrun_count (r_ucnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic f, input logic [11:0] e0, input logic [11:0] e1);
    chk({tag, ".frame"}, 48'(frame), 48'(f));
    chk({tag, ".p0"},    48'(p0),    48'(e0));
    chk({tag, ".p1"},    48'(p1),    48'(e1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; tvalid = 1'b0; tdata = '0;
    r_enable = 1'b0; r_tvalid = 1'b0; r_tdata = '0;
    step(); step();
    rst = 1'b0;
    chk_bus("reset", 1'b0, 12'h000, 12'h000);
    chk("reset.tready", 48'(tready), 48'd1);
    chk("reset.active", 48'(act), 48'd0);
    chk("reset.underrun", 48'(urun), 48'd0);
    chk("reset.ucount", 48'(ucnt), 48'd0);

    // Basic framing of two queued words.
    tvalid = 1'b1; tdata = 48'h00F_00E_00D_00C; step();
    tdata = 48'h013_012_011_010; step();
    tvalid = 1'b0; enable = 1'b1; step();
    chk("prime.active", 48'(act), 48'd0);
    chk_bus("prime", 1'b0, 12'h000, 12'h000);
    step(); chk_bus("w0.ch0", 1'b1, 12'h00C, 12'h00D);
    chk("w0.active", 48'(act), 48'd1);
    step(); chk_bus("w0.ch1", 1'b0, 12'h00E, 12'h00F);
    step(); chk_bus("w1.ch0", 1'b1, 12'h010, 12'h011);
    chk("w1.ucount", 48'(ucnt), 48'd0);
    step(); chk_bus("w1.ch1", 1'b0, 12'h012, 12'h013);
    chk("w1.underrun", 48'(urun), 48'd0);

    // FIFO now empty: zero pairs, frame keeps toggling, count per pair.
    step(); chk_bus("ur1.ch0", 1'b1, 12'h000, 12'h000);
    chk("ur1.underrun", 48'(urun), 48'd1);
    chk("ur1.ucount", 48'(ucnt), 48'd1);
    step(); chk_bus("ur1.ch1", 1'b0, 12'h000, 12'h000);
    step(); chk("ur2.ucount", 48'(ucnt), 48'd2);
    chk("ur2.frame", 48'(frame), 48'd1);
    step(); step(); chk("ur3.ucount", 48'(ucnt), 48'd3);
    step(); chk("ur3.ch1.frame", 48'(frame), 48'd0);

    // Word arriving on the underrun edge is queued for the following pair.
    tvalid = 1'b1; tdata = 48'h123_456_789_ABC; step();
    tvalid = 1'b0;
    chk_bus("ur4.ch0", 1'b1, 12'h000, 12'h000);
    chk("ur4.ucount", 48'(ucnt), 48'd4);
    step(); chk_bus("ur4.ch1", 1'b0, 12'h000, 12'h000);
    step(); chk_bus("late.ch0", 1'b1, 12'hABC, 12'h789);
    step(); chk_bus("late.ch1", 1'b0, 12'h456, 12'h123);
    enable = 1'b0; step();
    chk_bus("idle1", 1'b0, 12'h000, 12'h000);
    chk("idle1.active", 48'(act), 48'd0);
    chk("idle1.ucount", 48'(ucnt), 48'd4);

    // Fill the FIFO with enable low: four accepted, fifth refused.
    tvalid = 1'b1;
    tdata = 48'h004_003_002_001; step();
    tdata = 48'h008_007_006_005; step();
    tdata = 48'h00C_00B_00A_009; step();
    chk("fill3.tready", 48'(tready), 48'd1);
    tdata = 48'h010_00F_00E_00D; step();
    chk("full.tready", 48'(tready), 48'd0);
    tdata = 48'h014_013_012_011; step();
    chk("full2.tready", 48'(tready), 48'd0);
    enable = 1'b1; step();
    chk("prime.full.tready", 48'(tready), 48'd0);
    step(); chk_bus("a.ch0", 1'b1, 12'h001, 12'h002);
    chk("afterpop.tready", 48'(tready), 48'd1);

    // Drop enable in CH0: the CH1 slot still goes out, then IDLE.
    enable = 1'b0; step();
    tvalid = 1'b0;
    chk_bus("a.ch1", 1'b0, 12'h003, 12'h004);
    chk("refill.tready", 48'(tready), 48'd0);
    step(); chk_bus("drop.idle", 1'b0, 12'h000, 12'h000);
    chk("drop.active", 48'(act), 48'd0);
    step();
    enable = 1'b1; step(); step();
    chk_bus("b.ch0", 1'b1, 12'h005, 12'h006);
    step(); chk_bus("b.ch1", 1'b0, 12'h007, 12'h008);
    step(); chk_bus("c.ch0", 1'b1, 12'h009, 12'h00A);
    step(); step(); chk_bus("d.ch0", 1'b1, 12'h00D, 12'h00E);
    step(); step(); chk_bus("e.ch0", 1'b1, 12'h011, 12'h012);
    step(); chk_bus("e.ch1", 1'b0, 12'h013, 12'h014);
    chk("e.ucount", 48'(ucnt), 48'd4);
    step(); step();
    chk("ur5.ucount", 48'(ucnt), 48'd5);
    chk("ur5.ch1.frame", 48'(frame), 48'd0);
    chk("ur5.ch1.active", 48'(act), 48'd1);

    // Reset mid-frame in CH1 aborts immediately.
    rst = 1'b1; step();
    rst = 1'b0; enable = 1'b0;
    chk_bus("rst.mid", 1'b0, 12'h000, 12'h000);
    chk("rst.mid.ucount", 48'(ucnt), 48'd0);
    chk("rst.mid.underrun", 48'(urun), 48'd0);
    chk("rst.mid.tready", 48'(tready), 48'd1);
    chk("rst.mid.active", 48'(act), 48'd0);

    // START_LEVEL boundary: one word is not enough to leave PRIME.
    tvalid = 1'b1; tdata = 48'h0AA_0BB_0CC_0DD; step();
    tvalid = 1'b0; enable = 1'b1; step(); step();
    chk("lvl1.active", 48'(act), 48'd0);
    tvalid = 1'b1; tdata = 48'h7FF_800_001_FFF; step();
    tvalid = 1'b0;
    chk("lvl1b.active", 48'(act), 48'd0);
    step(); chk_bus("f.ch0", 1'b1, 12'h0DD, 12'h0CC);
    step(); chk_bus("f.ch1", 1'b0, 12'h0BB, 12'h0AA);
    step(); chk_bus("g.ch0", 1'b1, 12'hFFF, 12'h001);
    enable = 1'b0;
    step(); chk_bus("g.ch1", 1'b0, 12'h800, 12'h7FF);
    step(); chk("g.idle.active", 48'(act), 48'd0);
    chk("g.ucount", 48'(ucnt), 48'd0);

    // Reversed channel order on the second instance.
    r_tvalid = 1'b1; r_tdata = 48'h444_333_222_111; step();
    r_tvalid = 1'b0; r_enable = 1'b1; step(); step();
    chk("rev.ch0.frame", 48'(r_frame), 48'd1);
    chk("rev.ch0.p0", 48'(r_p0), 48'h333);
    chk("rev.ch0.p1", 48'(r_p1), 48'h444);
    r_enable = 1'b0; step();
    chk("rev.ch1.frame", 48'(r_frame), 48'd0);
    chk("rev.ch1.p0", 48'(r_p0), 48'h111);
    chk("rev.ch1.p1", 48'(r_p1), 48'h222);
    step();
    chk("rev.idle.active", 48'(r_act), 48'd0);
    chk("rev.ucount", 48'(r_ucnt), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
